// File: rtl/pong_pkg.sv
// Shared state and winner codes for the pong match sequencer, plus the score ceiling
// and a helper that picks the leader from two scores.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    localparam int MAX_SCORE = 99;

    function automatic winner_e leader(input logic [6:0] score_a, input logic [6:0] score_b);
        if (score_a > score_b)      return WIN_A;
        else if (score_b > score_a) return WIN_B;
        else                        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-side signal bundle for the match sequencer: keys, paddle/ball events and frame pacing in,
// animation freeze, score strobes and overlay status out.
interface pong_match_ctrl_if;
    logic       frame_tick;
    logic [1:0] btnA;
    logic [1:0] btnB;
    logic       hit_A;
    logic       hit_B;
    logic       miss;
    logic       gra_still;
    logic       d_inc_A;
    logic       d_inc_B;
    logic       d_clr;
    logic       timer_busy;
    logic [7:0] balls_left;
    logic [2:0] state;
    logic [1:0] winner;

    modport master (
        output frame_tick, btnA, btnB, hit_A, hit_B, miss,
        input  gra_still, d_inc_A, d_inc_B, d_clr, timer_busy, balls_left, state, winner
    );

    modport slave (
        input  frame_tick, btnA, btnB, hit_A, hit_B, miss,
        output gra_still, d_inc_A, d_inc_B, d_clr, timer_busy, balls_left, state, winner
    );
endinterface

// File: rtl/pong_frame_timer.sv
// Frame-paced down counter: load wins over counting, a tick in the load cycle is ignored,
// and the counter rests at zero (done) until loaded again.
module pong_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (frame_tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state, serve hand-off, ball budget and win detection.
// Define PONG_AUTO_SERVE_EN to let SERVE fall through to PLAY after AUTO_FRAMES idle frames.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS        = 3,
    parameter int WIN_SCORE    = 11,
    parameter int DELAY_FRAMES = 120,
    parameter int AUTO_FRAMES  = 300
) (
    input  logic              clk,
    input  logic              reset_n,
    pong_match_ctrl_if.slave  bus
);

    // The one timer serves both the POINT/OVER hold and the auto-serve wait, so size it for both.
    localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
    localparam int TW     = (AUTO_W > 8) ? AUTO_W : 8;

    localparam logic [7:0]    BALLS_EFF = (BALLS == 0) ? 8'd1 : 8'(BALLS);
    localparam logic [6:0]    WIN_LIM   = 7'(WIN_SCORE);
    localparam logic [6:0]    SCORE_MAX = 7'(MAX_SCORE);
    localparam logic [TW-1:0] DELAY_LD  = TW'(DELAY_FRAMES);

    state_e        state_q, state_d;
    winner_e       winner_q;
    logic [6:0]    score_a_q, score_b_q, score_a_d, score_b_d;
    logic [7:0]    balls_q;
    logic          gra_still_q, d_inc_a_q, d_inc_b_q, d_clr_q;
    logic          key_press, hit_a_ok, hit_b_ok, win;
    logic          timer_load, timer_done;
    logic [TW-1:0] timer_load_val, timer_count;

    assign key_press = (bus.btnA != 2'b00) || (bus.btnB != 2'b00);
    assign hit_a_ok  = bus.hit_A && !bus.miss && (score_a_q != SCORE_MAX);
    assign hit_b_ok  = bus.hit_B && !bus.miss && (score_b_q != SCORE_MAX);
    assign score_a_d = score_a_q + {6'd0, hit_a_ok};
    assign score_b_d = score_b_q + {6'd0, hit_b_ok};
    assign win       = (score_a_d >= WIN_LIM) || (score_b_d >= WIN_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (key_press) state_d = ST_SERVE;
`ifdef PONG_AUTO_SERVE_EN
            ST_SERVE: if (key_press || timer_done) state_d = ST_PLAY;
`else
            ST_SERVE: if (key_press) state_d = ST_PLAY;
`endif
            ST_PLAY: begin
                if (bus.miss)  state_d = (balls_q <= 8'd1) ? ST_OVER : ST_POINT;
                else if (win)  state_d = ST_OVER;
            end
            ST_POINT: if (timer_done) state_d = ST_SERVE;
            ST_OVER:  if (timer_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every state change reloads the timer with the hold time of the state being entered.
    always_comb begin
        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        case (state_d)
            ST_POINT, ST_OVER: timer_load_val = DELAY_LD;
`ifdef PONG_AUTO_SERVE_EN
            ST_SERVE:          timer_load_val = TW'(AUTO_FRAMES);
`endif
            default:           timer_load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gra_still_q <= 1'b1;
            d_inc_a_q   <= 1'b0;
            d_inc_b_q   <= 1'b0;
            d_clr_q     <= 1'b1;
            balls_q     <= BALLS_EFF;
            winner_q    <= WIN_NONE;
            score_a_q   <= '0;
            score_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            gra_still_q <= (state_d != ST_PLAY);
            d_clr_q     <= (state_d == ST_IDLE);
            d_inc_a_q   <= 1'b0;
            d_inc_b_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    balls_q   <= BALLS_EFF;
                    score_a_q <= '0;
                    score_b_q <= '0;
                    winner_q  <= WIN_NONE;
                end
                ST_PLAY: begin
                    if (bus.miss) begin
                        balls_q <= (balls_q == 8'd0) ? 8'd0 : balls_q - 8'd1;
                    end else begin
                        score_a_q <= score_a_d;
                        score_b_q <= score_b_d;
                        d_inc_a_q <= hit_a_ok;
                        d_inc_b_q <= hit_b_ok;
                        if (win) winner_q <= leader(score_a_d, score_b_d);
                    end
                end
                ST_OVER: begin
                    if (winner_q == WIN_NONE) winner_q <= leader(score_a_q, score_b_q);
                end
                default: ;
            endcase
        end
    end

    pong_frame_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_val   (timer_load_val),
        .frame_tick (bus.frame_tick),
        .count      (timer_count),
        .done       (timer_done)
    );

    assign bus.gra_still  = gra_still_q;
    assign bus.d_inc_A    = d_inc_a_q;
    assign bus.d_inc_B    = d_inc_b_q;
    assign bus.d_clr      = d_clr_q;
    assign bus.timer_busy = (timer_count != '0);
    assign bus.balls_left = balls_q;
    assign bus.state      = state_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised bench for pong_match_ctrl against a cycle-level match model built from the game rules.
module tb_pong_match_ctrl;

    localparam int BALLS        = 3;
    localparam int WIN_SCORE    = 4;
    localparam int DELAY_FRAMES = 40;
    localparam int AUTO_FRAMES  = 30;
`ifdef PONG_AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .BALLS        (BALLS),
        .WIN_SCORE    (WIN_SCORE),
        .DELAY_FRAMES (DELAY_FRAMES),
        .AUTO_FRAMES  (AUTO_FRAMES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model of the match: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
    int m_phase, m_balls, m_sa, m_sb, m_win, m_frames;
    bit m_inc_a, m_inc_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lead(input int a, input int b);
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_balls = BALLS; m_sa = 0; m_sb = 0;
        m_win = 0; m_frames = 0; m_inc_a = 0; m_inc_b = 0;
    endtask

    task automatic model_step(input bit key, input bit ha, input bit hb, input bit ms, input bit ft);
        int nxt;
        nxt = m_phase;
        m_inc_a = 0;
        m_inc_b = 0;
        case (m_phase)
            0: begin
                m_balls = BALLS; m_sa = 0; m_sb = 0; m_win = 0;
                if (key) nxt = 1;
            end
            1: if (key || (AUTO && m_frames == 0)) nxt = 2;
            2: begin
                if (ms) begin
                    nxt = (m_balls <= 1) ? 4 : 3;
                    if (m_balls > 0) m_balls--;
                end else begin
                    if (ha && m_sa < 99) begin m_sa++; m_inc_a = 1; end
                    if (hb && m_sb < 99) begin m_sb++; m_inc_b = 1; end
                    if (m_sa >= WIN_SCORE || m_sb >= WIN_SCORE) begin
                        nxt = 4;
                        m_win = lead(m_sa, m_sb);
                    end
                end
            end
            3: if (m_frames == 0) nxt = 1;
            4: begin
                if (m_win == 0) m_win = lead(m_sa, m_sb);
                if (m_frames == 0) nxt = 0;
            end
            default: nxt = 0;
        endcase
        // Entering a phase starts its hold; the tick of that same cycle does not count.
        if (nxt != m_phase) begin
            if (nxt == 3 || nxt == 4)  m_frames = DELAY_FRAMES;
            else if (nxt == 1 && AUTO) m_frames = AUTO_FRAMES;
            else                       m_frames = 0;
        end else if (ft && m_frames > 0) begin
            m_frames--;
        end
        m_phase = nxt;
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, "state"},      32'(bus.state),      32'(m_phase));
        check_eq({pfx, "gra_still"},  32'(bus.gra_still),  32'(m_phase != 2));
        check_eq({pfx, "d_inc_A"},    32'(bus.d_inc_A),    32'(m_inc_a));
        check_eq({pfx, "d_inc_B"},    32'(bus.d_inc_B),    32'(m_inc_b));
        check_eq({pfx, "d_clr"},      32'(bus.d_clr),      32'(m_phase == 0));
        check_eq({pfx, "timer_busy"}, 32'(bus.timer_busy), 32'(m_frames != 0));
        check_eq({pfx, "balls_left"}, 32'(bus.balls_left), 32'(m_balls));
        check_eq({pfx, "winner"},     32'(bus.winner),     32'(m_win));
    endtask

    // Called at a falling edge: drive, let the rising edge happen, then compare at the next falling edge.
    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic ha, input logic hb,
                        input logic ms, input logic ft);
        bus.btnA = a; bus.btnB = b; bus.hit_A = ha; bus.hit_B = hb;
        bus.miss = ms; bus.frame_tick = ft;
        @(posedge clk);
        model_step((a != 2'b00) || (b != 2'b00), ha, hb, ms, ft);
        @(negedge clk);
        check_outputs("");
    endtask

    task automatic do_reset();
        bus.btnA = 2'b00; bus.btnB = 2'b00; bus.hit_A = 1'b0; bus.hit_B = 1'b0;
        bus.miss = 1'b0; bus.frame_tick = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_");
        repeat (3) @(negedge clk);
        check_outputs("rst_hold_");
        reset_n = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        logic [1:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            b = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(a, b, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        int guard;
        @(negedge clk);
        do_reset();

        // Directed opening: serve by A, launch by B, double hit, then hit masked by a miss.
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        random_cycles(12000);

        // Steer into PLAY, then pull reset mid-rally.
        guard = 0;
        while (m_phase != 2 && guard < 3000) begin
            step((m_phase == 0 || m_phase == 1) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        check_eq("reach_play", 32'(m_phase == 2), 32'd1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();

        random_cycles(12000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
